asignador_cubos_param: RTL and testbench
========================================

// Module: asignador_cubos_param
// PURPOSE
// - Parametrised successor to the fixed 5-cube spawn chain (position control, next-cube register, enabler).
// - On each spawn tick, draws a random x, rejects positions too close to live cubes (bounded retries),
//   allocates a free cube slot and pulses that slot's start with the accepted x.
// - Sits between timer/LFSR and the Cubo instances; tracks slot occupancy from per-cube done pulses.
// PARAMETERS
// - NUM_CUBOS       5   number of cube slots (1..16)
// - ANCHO_X         9   width of x positions
// - SEPARACION_MIN  32  min |x_new - x_live| accepted (pixels)
// - REINTENTOS      4   max candidate checks per spawn tick (>=1)
// PORTS
// - clk                  in  1                  system clock
// - reset                in  1                  synchronous, active-high reset
// - habilitar            in  1                  game running; low aborts pending search
// - pulso_tiempo         in  1                  1-cycle spawn request
// - posicion_x_aleatoria in  ANCHO_X            free-running random x (changes every cycle)
// - pos_x_cubos          in  NUM_CUBOS*ANCHO_X  live x of slot i at [i*ANCHO_X +: ANCHO_X]
// - cubo_terminado       in  NUM_CUBOS          1-cycle pulse: slot i fell off screen or was caught
// - start_cubos          out NUM_CUBOS          one-hot 1-cycle start pulse, registered
// - pos_seleccionada     out ANCHO_X            accepted x; valid with start_cubos, held until next accept
// - cubos_activos        out NUM_CUBOS          occupancy mask, registered
// - lleno                out 1                  &cubos_activos
// - descartados          out 8                  dropped spawn requests, saturates at 255
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; retry count 0; RR pointer 0.
// - IDLE: pulso_tiempo&habilitar&~lleno -> latch candidate, intentos=0, -> VERIFICAR.
//   pulso_tiempo&habilitar&lleno -> descartados+1, stay IDLE.
// - VERIFICAR (1 cycle/check): conflict = any active i with |pos_x_cubos[i]-cand| < SEPARACION_MIN
//   (abs diff computed in ANCHO_X+1 bits, unsigned). No conflict -> ASIGNAR.
//   Conflict & intentos<REINTENTOS-1 -> intentos+1, re-latch posicion_x_aleatoria, stay.
//   Conflict & intentos==REINTENTOS-1 -> descartados+1, -> IDLE.
// - ASIGNAR: start_cubos[k]=1 for exactly one cycle, pos_seleccionada=cand, cubos_activos[k] set; -> IDLE.
// - Latency: request edge -> start_cubos high 2 cycles later with 0 retries; +1 cycle per retry.
// - Free slot chosen at VERIFICAR->ASIGNAR; never an active slot, so at most one start bit set.
// - cubo_terminado[i] clears cubos_activos[i] on next edge; pulse on inactive slot ignored.
//   Release and assign of different slots in same cycle both take effect.
// - Slot freed during VERIFICAR is immediately free for that check; slot going full mid-search
//   (impossible: only this block sets bits) needs no handling.
// - pulso_tiempo outside IDLE: descartados+1, request ignored.
// - habilitar low in VERIFICAR/ASIGNAR: -> IDLE next edge, no start, nothing counted; mask kept.
// - habilitar low does not clear cubos_activos; live cubes still release normally.
// - reset mid-search: all state/outputs 0 next cycle, no start emitted.
// CONFIGURATION
// - ASIGNACION_ROUND_ROBIN_EN defined: slot search starts at (last assigned index+1) mod NUM_CUBOS,
//   wraps; pointer updated on each assign.
// - Undefined: lowest-index free slot always wins; no pointer register.
// TESTING (NUM_CUBOS=5, SEPARACION_MIN=32, REINTENTOS=4, habilitar=1)
// - Empty, pulso at x=100 -> 2 cycles later start_cubos=00001, pos_seleccionada=100, cubos_activos=00001.
// - Slot0 at x=100; candidates 120 then 200 -> 1 retry, start_cubos=00010 after 3 cycles, pos=200.
// - Slot0 at x=100; candidate stuck at 110 -> 4 checks, no start, descartados=1, state IDLE.
// - 5 slots active, pulso -> lleno=1, descartados+1; then cubo_terminado=00100, pulso -> start_cubos=00100.
// - Macro on: release slot0 after 3 spawns (00111), next spawn -> 01000 (macro off -> 00001).
// - Reset in VERIFICAR -> next cycle all outputs 0; 256 full-mask pulsos -> descartados stays 255.

Source files
------------

// File: rtl/asignador_cubos_param.sv
// Cube spawn allocator: draws a random x, rejects positions too close to live cubes
// (bounded retries), and starts one free cube slot. Optional macro: ASIGNACION_ROUND_ROBIN_EN.
module asignador_cubos_param #(
   parameter int NUM_CUBOS      = 5,
   parameter int ANCHO_X        = 9,
   parameter int SEPARACION_MIN = 32,
   parameter int REINTENTOS     = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         habilitar,
   input  logic                         pulso_tiempo,
   input  logic [ANCHO_X-1:0]           posicion_x_aleatoria,
   input  logic [NUM_CUBOS*ANCHO_X-1:0] pos_x_cubos,
   input  logic [NUM_CUBOS-1:0]         cubo_terminado,
   output logic [NUM_CUBOS-1:0]         start_cubos,
   output logic [ANCHO_X-1:0]           pos_seleccionada,
   output logic [NUM_CUBOS-1:0]         cubos_activos,
   output logic                         lleno,
   output logic [7:0]                   descartados
);

   localparam int IW = (NUM_CUBOS > 1) ? $clog2(NUM_CUBOS) : 1;
   localparam int CW = (REINTENTOS > 1) ? $clog2(REINTENTOS) : 1;
   localparam logic [ANCHO_X:0] SEP = (ANCHO_X+1)'(SEPARACION_MIN);
   localparam logic [CW-1:0]    LIM = CW'(REINTENTOS - 1);

   typedef enum logic [1:0] {IDLE, VERIFICAR, ASIGNAR} estado_t;

   estado_t              r_estado, w_estado_sig;
   logic [ANCHO_X-1:0]   r_cand;
   logic [CW-1:0]        r_intentos, w_intentos_sig;
   logic [IW-1:0]        r_slot;
   logic [NUM_CUBOS-1:0] r_start;
   logic [ANCHO_X-1:0]   r_pos;
   logic [NUM_CUBOS-1:0] r_activos;
   logic [7:0]           r_desc;

   logic                 w_latch, w_fijar_slot, w_emitir;
   logic                 w_drop_busca, w_drop_pulso;
   logic                 w_conflicto;
   logic                 w_libre_ok;
   logic [IW-1:0]        w_libre;
   logic [NUM_CUBOS-1:0] w_vivos;
   logic [NUM_CUBOS-1:0] w_set;
   logic [1:0]           w_inc;
   logic [8:0]           w_suma;
   logic [7:0]           w_desc_sig;

   function automatic logic [ANCHO_X:0] abs_dif(input logic [ANCHO_X-1:0] a,
                                                input logic [ANCHO_X-1:0] b);
      logic [ANCHO_X:0] ea;
      logic [ANCHO_X:0] eb;
      ea = {1'b0, a};
      eb = {1'b0, b};
      return (ea >= eb) ? (ea - eb) : (eb - ea);
   endfunction

   // A slot released this very cycle already counts as free for the check and the search.
   assign w_vivos = r_activos & ~cubo_terminado;

   always_comb begin
      w_conflicto = 1'b0;
      for (int unsigned i = 0; i < NUM_CUBOS; i++) begin
         if (w_vivos[i] && (abs_dif(pos_x_cubos[i*ANCHO_X +: ANCHO_X], r_cand) < SEP))
            w_conflicto = 1'b1;
      end
   end

`ifdef ASIGNACION_ROUND_ROBIN_EN
   logic [IW-1:0] r_ptr;
   logic [IW:0]   w_sum;

   always_comb begin
      w_libre_ok = 1'b0;
      w_libre    = '0;
      w_sum      = '0;
      for (int unsigned j = 0; j < NUM_CUBOS; j++) begin
         w_sum = {1'b0, r_ptr} + (IW+1)'(j);
         if (w_sum >= (IW+1)'(NUM_CUBOS))
            w_sum = w_sum - (IW+1)'(NUM_CUBOS);
         if (!w_libre_ok &&
             ((~w_vivos & (NUM_CUBOS'(1) << w_sum[IW-1:0])) != '0)) begin
            w_libre_ok = 1'b1;
            w_libre    = w_sum[IW-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_ptr <= '0;
      else if (w_emitir)
         r_ptr <= (r_slot == IW'(NUM_CUBOS - 1)) ? '0 : (r_slot + 1'b1);
   end
`else
   always_comb begin
      w_libre_ok = 1'b0;
      w_libre    = '0;
      for (int unsigned j = 0; j < NUM_CUBOS; j++) begin
         if (!w_libre_ok && !w_vivos[j]) begin
            w_libre_ok = 1'b1;
            w_libre    = IW'(j);
         end
      end
   end
`endif

   always_comb begin
      w_estado_sig   = r_estado;
      w_intentos_sig = r_intentos;
      w_latch        = 1'b0;
      w_fijar_slot   = 1'b0;
      w_emitir       = 1'b0;
      w_drop_busca   = 1'b0;
      w_drop_pulso   = 1'b0;
      case (r_estado)
         IDLE: begin
            if (pulso_tiempo && habilitar) begin
               if (&r_activos) begin
                  w_drop_pulso = 1'b1;
               end else begin
                  w_latch        = 1'b1;
                  w_intentos_sig = '0;
                  w_estado_sig   = VERIFICAR;
               end
            end
         end
         VERIFICAR: begin
            if (!habilitar) begin
               w_estado_sig = IDLE;
            end else begin
               w_drop_pulso = pulso_tiempo;
               if (!w_conflicto && w_libre_ok) begin
                  w_fijar_slot = 1'b1;
                  w_estado_sig = ASIGNAR;
               end else if (r_intentos < LIM) begin
                  w_intentos_sig = r_intentos + 1'b1;
                  w_latch        = 1'b1;
               end else begin
                  w_drop_busca = 1'b1;
                  w_estado_sig = IDLE;
               end
            end
         end
         ASIGNAR: begin
            w_estado_sig = IDLE;
            if (habilitar) begin
               w_drop_pulso = pulso_tiempo;
               w_emitir     = 1'b1;
            end
         end
         default: w_estado_sig = IDLE;
      endcase
   end

   assign w_set      = w_emitir ? (NUM_CUBOS'(1) << r_slot) : '0;
   assign w_inc      = {1'b0, w_drop_busca} + {1'b0, w_drop_pulso};
   assign w_suma     = {1'b0, r_desc} + {7'b0, w_inc};
   assign w_desc_sig = w_suma[8] ? 8'hFF : w_suma[7:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_estado   <= IDLE;
         r_cand     <= '0;
         r_intentos <= '0;
         r_slot     <= '0;
         r_start    <= '0;
         r_pos      <= '0;
         r_activos  <= '0;
         r_desc     <= '0;
      end else begin
         r_estado   <= w_estado_sig;
         r_intentos <= w_intentos_sig;
         r_desc     <= w_desc_sig;
         r_start    <= w_set;
         r_activos  <= (r_activos & ~cubo_terminado) | w_set;
         if (w_latch)
            r_cand <= posicion_x_aleatoria;
         if (w_fijar_slot)
            r_slot <= w_libre;
         if (w_emitir)
            r_pos <= r_cand;
      end
   end

   assign start_cubos      = r_start;
   assign pos_seleccionada = r_pos;
   assign cubos_activos    = r_activos;
   assign lleno            = &r_activos;
   assign descartados      = r_desc;

endmodule

// File: tb/tb_asignador_cubos_param.sv
// Directed bench for asignador_cubos_param (5 slots, 9-bit x, min gap 32, 4 checks per request).
module tb_asignador_cubos_param;

   localparam int N = 5;
   localparam int W = 9;

   logic           clk = 1'b0;
   logic           reset;
   logic           habilitar;
   logic           pulso_tiempo;
   logic [W-1:0]   posicion_x_aleatoria;
   logic [N*W-1:0] pos_x_cubos;
   logic [N-1:0]   cubo_terminado;
   logic [N-1:0]   start_cubos;
   logic [W-1:0]   pos_seleccionada;
   logic [N-1:0]   cubos_activos;
   logic           lleno;
   logic [7:0]     descartados;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   asignador_cubos_param #(
      .NUM_CUBOS(N),
      .ANCHO_X(W),
      .SEPARACION_MIN(32),
      .REINTENTOS(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .habilitar(habilitar),
      .pulso_tiempo(pulso_tiempo),
      .posicion_x_aleatoria(posicion_x_aleatoria),
      .pos_x_cubos(pos_x_cubos),
      .cubo_terminado(cubo_terminado),
      .start_cubos(start_cubos),
      .pos_seleccionada(pos_seleccionada),
      .cubos_activos(cubos_activos),
      .lleno(lleno),
      .descartados(descartados)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Request on one edge, then two more edges: a zero-retry start is visible afterwards.
   task automatic spawn(input logic [W-1:0] x);
      posicion_x_aleatoria = x;
      pulso_tiempo = 1'b1;
      tick();
      pulso_tiempo = 1'b0;
      tick();
      tick();
   endtask

   task automatic release_slot(input logic [N-1:0] m);
      cubo_terminado = m;
      tick();
      cubo_terminado = '0;
   endtask

   initial begin
      reset = 1'b1;
      habilitar = 1'b1;
      pulso_tiempo = 1'b0;
      posicion_x_aleatoria = '0;
      pos_x_cubos = '0;
      cubo_terminado = '0;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_start", 32'(start_cubos), 0);
      chk("rst_pos", 32'(pos_seleccionada), 0);
      chk("rst_act", 32'(cubos_activos), 0);
      chk("rst_lleno", 32'(lleno), 0);
      chk("rst_desc", 32'(descartados), 0);

      // Empty board, x=100: start two edges after the request.
      posicion_x_aleatoria = 9'd100;
      pulso_tiempo = 1'b1;
      tick();
      pulso_tiempo = 1'b0;
      chk("s1_start_e0", 32'(start_cubos), 0);
      tick();
      chk("s1_start_e1", 32'(start_cubos), 0);
      tick();
      chk("s1_start", 32'(start_cubos), 32'b00001);
      chk("s1_pos", 32'(pos_seleccionada), 100);
      chk("s1_act", 32'(cubos_activos), 32'b00001);
      pos_x_cubos[0*W +: W] = 9'd100;
      tick();
      chk("s1_pulse_len", 32'(start_cubos), 0);
      chk("s1_act_hold", 32'(cubos_activos), 32'b00001);

      // 120 conflicts with slot0, retry draws 200.
      posicion_x_aleatoria = 9'd120;
      pulso_tiempo = 1'b1;
      tick();
      pulso_tiempo = 1'b0;
      posicion_x_aleatoria = 9'd200;
      tick();
      tick();
      chk("s2_start_early", 32'(start_cubos), 0);
      tick();
      chk("s2_start", 32'(start_cubos), 32'b00010);
      chk("s2_pos", 32'(pos_seleccionada), 200);
      chk("s2_act", 32'(cubos_activos), 32'b00011);
      pos_x_cubos[1*W +: W] = 9'd200;

      // Candidate stuck at 110: four rejected checks, then dropped.
      posicion_x_aleatoria = 9'd110;
      pulso_tiempo = 1'b1;
      tick();
      pulso_tiempo = 1'b0;
      tick();
      tick();
      tick();
      chk("s3_desc_mid", 32'(descartados), 0);
      tick();
      chk("s3_desc", 32'(descartados), 1);
      chk("s3_start", 32'(start_cubos), 0);
      tick();
      tick();
      chk("s3_start_late", 32'(start_cubos), 0);
      chk("s3_act", 32'(cubos_activos), 32'b00011);
      spawn(9'd300);
      chk("s3_idle_start", 32'(start_cubos), 32'b00100);
      chk("s3_idle_act", 32'(cubos_activos), 32'b00111);
      pos_x_cubos[2*W +: W] = 9'd300;

      // Slot0 released with 00111 active; next slot depends on allocation policy.
      release_slot(5'b00001);
      chk("rr_act_rel", 32'(cubos_activos), 32'b00110);
      spawn(9'd400);
`ifdef ASIGNACION_ROUND_ROBIN_EN
      chk("rr_start", 32'(start_cubos), 32'b01000);
      pos_x_cubos[3*W +: W] = 9'd400;
      spawn(9'd20);
      chk("fill_a", 32'(start_cubos), 32'b10000);
      pos_x_cubos[4*W +: W] = 9'd20;
      spawn(9'd480);
      chk("fill_b", 32'(start_cubos), 32'b00001);
      pos_x_cubos[0*W +: W] = 9'd480;
`else
      chk("rr_start", 32'(start_cubos), 32'b00001);
      pos_x_cubos[0*W +: W] = 9'd400;
      spawn(9'd20);
      chk("fill_a", 32'(start_cubos), 32'b01000);
      pos_x_cubos[3*W +: W] = 9'd20;
      spawn(9'd480);
      chk("fill_b", 32'(start_cubos), 32'b10000);
      pos_x_cubos[4*W +: W] = 9'd480;
`endif
      chk("full_act", 32'(cubos_activos), 32'b11111);
      chk("full_lleno", 32'(lleno), 1);

      // Request with every slot busy is dropped.
      posicion_x_aleatoria = 9'd300;
      pulso_tiempo = 1'b1;
      tick();
      pulso_tiempo = 1'b0;
      chk("full_desc", 32'(descartados), 2);
      tick();
      tick();
      chk("full_nostart", 32'(start_cubos), 0);

      // Slot2 freed; a second pulse while searching is counted but ignored.
      release_slot(5'b00100);
      chk("rel_act", 32'(cubos_activos), 32'b11011);
      chk("rel_lleno", 32'(lleno), 0);
      posicion_x_aleatoria = 9'd300;
      pulso_tiempo = 1'b1;
      tick();
      tick();
      pulso_tiempo = 1'b0;
      tick();
      chk("busy_start", 32'(start_cubos), 32'b00100);
      chk("busy_desc", 32'(descartados), 3);

      // habilitar low mid-search aborts silently.
      release_slot(5'b00100);
      pulso_tiempo = 1'b1;
      tick();
      pulso_tiempo = 1'b0;
      habilitar = 1'b0;
      tick();
      tick();
      tick();
      chk("abort_start", 32'(start_cubos), 0);
      chk("abort_desc", 32'(descartados), 3);
      chk("abort_act", 32'(cubos_activos), 32'b11011);
      habilitar = 1'b1;
      spawn(9'd300);
      chk("abort_recover", 32'(start_cubos), 32'b00100);

      // Reset while in VERIFICAR.
      release_slot(5'b00001);
      posicion_x_aleatoria = 9'd100;
      pulso_tiempo = 1'b1;
      tick();
      pulso_tiempo = 1'b0;
      reset = 1'b1;
      tick();
      chk("mrst_start", 32'(start_cubos), 0);
      chk("mrst_act", 32'(cubos_activos), 0);
      chk("mrst_pos", 32'(pos_seleccionada), 0);
      chk("mrst_desc", 32'(descartados), 0);
      reset = 1'b0;
      tick();
      tick();
      chk("mrst_nostart", 32'(start_cubos), 0);

      // Refill from empty, then saturate the drop counter.
      for (int i = 0; i < N; i++) begin
         spawn(W'(20 + 100 * i));
         chk("sat_fill", 32'(start_cubos), 32'(1) << i);
         pos_x_cubos[i*W +: W] = W'(20 + 100 * i);
      end
      pulso_tiempo = 1'b1;
      for (int i = 0; i < 260; i++) tick();
      pulso_tiempo = 1'b0;
      tick();
      chk("sat_desc", 32'(descartados), 255);
      chk("sat_lleno", 32'(lleno), 1);
      chk("sat_start", 32'(start_cubos), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
